// File: rtl/exe_stage.sv
// Execute stage: operand forwarding from MEM/WB, ALU, and the EXE/MEM pipeline register.
// The combinational ALU result is also exported for the EXE->ID bypass path.
module exe_stage #(
    parameter bit HAS_FORWARDING = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FLUSH,
    input  logic [31:0] Instr1_IN,
    input  logic [31:0] Instr1_PC_IN,
    input  logic        Request_Alt_PC,
    input  logic [31:0] Alt_PC,
    input  logic        Branch_prediction_IN,
    input  logic [4:0]  RegisterA1_IN,
    input  logic [31:0] OperandA1_IN,
    input  logic [4:0]  RegisterB1_IN,
    input  logic [31:0] OperandB1_IN,
    input  logic [4:0]  WriteRegister1_IN,
    input  logic [31:0] MemWriteData1_IN,
    input  logic        RegWrite1_IN,
    input  logic [5:0]  ALU_Control1_IN,
    input  logic        MemRead1_IN,
    input  logic        MemWrite1_IN,
    input  logic [4:0]  ShiftAmount1_IN,
    input  logic [4:0]  BypassReg1_MEMEXE,
    input  logic [31:0] BypassData1_MEMEXE,
    input  logic        BypassValid1_MEMEXE,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr1_PC_OUT,
    output logic [31:0] ALU_result1_OUT,
    output logic [4:0]  WriteRegister1_OUT,
    output logic [31:0] MemWriteData1_OUT,
    output logic        RegWrite1_OUT,
    output logic        MemRead1_OUT,
    output logic        MemWrite1_OUT,
    output logic [5:0]  ALU_Control1_OUT,
    output logic [31:0] Alt_PC1,
    output logic        Request_Alt_PC1,
    output logic        Branch_prediction_OUT,
    output logic [31:0] ALU_result_async1,
    output logic        ALU_result_async_valid1
);

    logic        fwd_a;
    logic        fwd_b;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] store_data;
    logic [31:0] alu_y;

    // $0 is hardwired to zero, so a MEM/WB write to it must never be forwarded.
    always_comb begin
        fwd_a = HAS_FORWARDING && BypassValid1_MEMEXE && (BypassReg1_MEMEXE != 5'd0)
                && (BypassReg1_MEMEXE == RegisterA1_IN);
        fwd_b = HAS_FORWARDING && BypassValid1_MEMEXE && (BypassReg1_MEMEXE != 5'd0)
                && (BypassReg1_MEMEXE == RegisterB1_IN);
        op_a       = fwd_a ? BypassData1_MEMEXE : OperandA1_IN;
        op_b       = fwd_b ? BypassData1_MEMEXE : OperandB1_IN;
        store_data = fwd_b ? BypassData1_MEMEXE : MemWriteData1_IN;
    end

    always_comb begin
        alu_y = 32'd0;
        case (ALU_Control1_IN)
            6'd0:    alu_y = op_a + op_b;
            6'd1:    alu_y = op_a - op_b;
            6'd2:    alu_y = op_a & op_b;
            6'd3:    alu_y = op_a | op_b;
            6'd4:    alu_y = op_a ^ op_b;
            6'd5:    alu_y = ~(op_a | op_b);
            6'd6:    alu_y = {31'd0, $signed(op_a) < $signed(op_b)};
            6'd7:    alu_y = {31'd0, op_a < op_b};
            6'd8:    alu_y = op_b << ShiftAmount1_IN;
            6'd9:    alu_y = op_b >> ShiftAmount1_IN;
            6'd10:   alu_y = $signed(op_b) >>> ShiftAmount1_IN;
            6'd11:   alu_y = op_b << op_a[4:0];
            6'd12:   alu_y = op_b >> op_a[4:0];
            6'd13:   alu_y = $signed(op_b) >>> op_a[4:0];
            6'd14:   alu_y = {op_b[15:0], 16'h0000};
            6'd15:   alu_y = op_b;
            6'd16:   alu_y = Instr1_PC_IN + 32'd8;
            default: alu_y = 32'd0;
        endcase
    end

    // Load results arrive from MEM, so a load's address is not a bypassable value.
    assign ALU_result_async1       = alu_y;
    assign ALU_result_async_valid1 = RegWrite1_IN & ~MemRead1_IN & (WriteRegister1_IN != 5'd0);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Instr1_OUT            <= 32'd0;
            Instr1_PC_OUT         <= 32'd0;
            ALU_result1_OUT       <= 32'd0;
            WriteRegister1_OUT    <= 5'd0;
            MemWriteData1_OUT     <= 32'd0;
            RegWrite1_OUT         <= 1'b0;
            MemRead1_OUT          <= 1'b0;
            MemWrite1_OUT         <= 1'b0;
            ALU_Control1_OUT      <= 6'd0;
            Alt_PC1               <= 32'd0;
            Request_Alt_PC1       <= 1'b0;
            Branch_prediction_OUT <= 1'b0;
        end else if (FLUSH) begin
            Instr1_OUT            <= 32'd0;
            Instr1_PC_OUT         <= 32'd0;
            ALU_result1_OUT       <= 32'd0;
            WriteRegister1_OUT    <= 5'd0;
            MemWriteData1_OUT     <= 32'd0;
            RegWrite1_OUT         <= 1'b0;
            MemRead1_OUT          <= 1'b0;
            MemWrite1_OUT         <= 1'b0;
            ALU_Control1_OUT      <= 6'd0;
            Alt_PC1               <= 32'd0;
            Request_Alt_PC1       <= 1'b0;
            Branch_prediction_OUT <= 1'b0;
        end else begin
            Instr1_OUT            <= Instr1_IN;
            Instr1_PC_OUT         <= Instr1_PC_IN;
            ALU_result1_OUT       <= alu_y;
            WriteRegister1_OUT    <= WriteRegister1_IN;
            MemWriteData1_OUT     <= store_data;
            RegWrite1_OUT         <= RegWrite1_IN;
            MemRead1_OUT          <= MemRead1_IN;
            MemWrite1_OUT         <= MemWrite1_IN;
            ALU_Control1_OUT      <= ALU_Control1_IN;
            Alt_PC1               <= Alt_PC;
            Request_Alt_PC1       <= Request_Alt_PC;
            Branch_prediction_OUT <= Branch_prediction_IN;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed corner cases plus randomized cycles against a
// behavioural model of forwarding, ALU and the pipeline register.
module tb_exe_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        FLUSH;
    logic [31:0] Instr1_IN, Instr1_PC_IN, Alt_PC, OperandA1_IN, OperandB1_IN;
    logic [31:0] MemWriteData1_IN, BypassData1_MEMEXE;
    logic        Request_Alt_PC, Branch_prediction_IN, RegWrite1_IN, MemRead1_IN;
    logic        MemWrite1_IN, BypassValid1_MEMEXE;
    logic [4:0]  RegisterA1_IN, RegisterB1_IN, WriteRegister1_IN, ShiftAmount1_IN;
    logic [4:0]  BypassReg1_MEMEXE;
    logic [5:0]  ALU_Control1_IN;

    logic [31:0] Instr1_OUT, Instr1_PC_OUT, ALU_result1_OUT, MemWriteData1_OUT, Alt_PC1;
    logic [31:0] ALU_result_async1;
    logic [4:0]  WriteRegister1_OUT;
    logic [5:0]  ALU_Control1_OUT;
    logic        RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT, Request_Alt_PC1;
    logic        Branch_prediction_OUT, ALU_result_async_valid1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_alu, exp_mwd, exp_instr, exp_pc, exp_alt;
    logic [31:0] exp_ctrl;
    logic        exp_valid;

    always #5 CLK = ~CLK;

    exe_stage #(.HAS_FORWARDING(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
        .Request_Alt_PC(Request_Alt_PC), .Alt_PC(Alt_PC),
        .Branch_prediction_IN(Branch_prediction_IN),
        .RegisterA1_IN(RegisterA1_IN), .OperandA1_IN(OperandA1_IN),
        .RegisterB1_IN(RegisterB1_IN), .OperandB1_IN(OperandB1_IN),
        .WriteRegister1_IN(WriteRegister1_IN), .MemWriteData1_IN(MemWriteData1_IN),
        .RegWrite1_IN(RegWrite1_IN), .ALU_Control1_IN(ALU_Control1_IN),
        .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
        .ShiftAmount1_IN(ShiftAmount1_IN),
        .BypassReg1_MEMEXE(BypassReg1_MEMEXE), .BypassData1_MEMEXE(BypassData1_MEMEXE),
        .BypassValid1_MEMEXE(BypassValid1_MEMEXE),
        .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
        .ALU_result1_OUT(ALU_result1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
        .MemWriteData1_OUT(MemWriteData1_OUT), .RegWrite1_OUT(RegWrite1_OUT),
        .MemRead1_OUT(MemRead1_OUT), .MemWrite1_OUT(MemWrite1_OUT),
        .ALU_Control1_OUT(ALU_Control1_OUT), .Alt_PC1(Alt_PC1),
        .Request_Alt_PC1(Request_Alt_PC1), .Branch_prediction_OUT(Branch_prediction_OUT),
        .ALU_result_async1(ALU_result_async1),
        .ALU_result_async_valid1(ALU_result_async_valid1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] val);
        if (BypassValid1_MEMEXE && BypassReg1_MEMEXE != 0 && BypassReg1_MEMEXE == src)
            return BypassData1_MEMEXE;
        return val;
    endfunction

    function automatic logic [31:0] ref_alu(input int code, input logic [31:0] a,
                                            input logic [31:0] b, input int sh,
                                            input logic [31:0] pc);
        logic [31:0] ones;
        logic [31:0] r;
        int sa;
        ones = 32'hFFFF_FFFF;
        sa = (code == 13) ? int'(a % 32) : sh;
        case (code)
            0:  r = a + b;
            1:  r = a + (~b + 1);
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = ~a & ~b;
            6:  r = (int'(a) < int'(b)) ? 1 : 0;
            7:  r = (longint'({32'd0, a}) < longint'({32'd0, b})) ? 1 : 0;
            8:  r = b << sh;
            9:  r = b >> sh;
            11: r = b << (a % 32);
            12: r = b >> (a % 32);
            14: r = b * 32'h0001_0000;
            15: r = b;
            16: r = pc + 8;
            10, 13: begin
                r = b >> sa;
                if (b[31]) r = r | ~(ones >> sa);
            end
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] reg_ctrl();
        return {Branch_prediction_OUT, Request_Alt_PC1, MemWrite1_OUT, MemRead1_OUT,
                RegWrite1_OUT, ALU_Control1_OUT, WriteRegister1_OUT};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_instr"}, Instr1_OUT, 0);
        check({tag, "_pc"}, Instr1_PC_OUT, 0);
        check({tag, "_alu"}, ALU_result1_OUT, 0);
        check({tag, "_mwd"}, MemWriteData1_OUT, 0);
        check({tag, "_altpc"}, Alt_PC1, 0);
        check({tag, "_ctrl"}, reg_ctrl(), 0);
    endtask

    task automatic set_quiet();
        FLUSH = 0; Instr1_IN = 32'h0000_0020; Instr1_PC_IN = 32'h0040_0000;
        Request_Alt_PC = 0; Alt_PC = 0; Branch_prediction_IN = 0;
        RegisterA1_IN = 1; OperandA1_IN = 0; RegisterB1_IN = 2; OperandB1_IN = 0;
        WriteRegister1_IN = 4; MemWriteData1_IN = 0; RegWrite1_IN = 1;
        ALU_Control1_IN = 0; MemRead1_IN = 0; MemWrite1_IN = 0; ShiftAmount1_IN = 0;
        BypassReg1_MEMEXE = 0; BypassData1_MEMEXE = 0; BypassValid1_MEMEXE = 0;
    endtask

    task automatic set_random();
        FLUSH = ($urandom_range(0, 7) == 0);
        Instr1_IN = $urandom; Instr1_PC_IN = $urandom & 32'hFFFF_FFFC;
        Request_Alt_PC = 1'($urandom); Alt_PC = $urandom; Branch_prediction_IN = 1'($urandom);
        RegisterA1_IN = 5'($urandom_range(0, 3)); RegisterB1_IN = 5'($urandom_range(0, 3));
        OperandA1_IN = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        OperandB1_IN = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
        WriteRegister1_IN = 5'($urandom_range(0, 3)); MemWriteData1_IN = $urandom;
        RegWrite1_IN = 1'($urandom); MemRead1_IN = 1'($urandom); MemWrite1_IN = 1'($urandom);
        ALU_Control1_IN = 6'($urandom_range(0, 20)); ShiftAmount1_IN = 5'($urandom);
        BypassReg1_MEMEXE = 5'($urandom_range(0, 3)); BypassData1_MEMEXE = $urandom;
        BypassValid1_MEMEXE = 1'($urandom);
    endtask

    // Called just after a falling edge with inputs settled; leaves time at the next falling edge.
    task automatic cycle_and_check(input string tag);
        logic [31:0] a, b;
        #1;
        a = fwd(RegisterA1_IN, OperandA1_IN);
        b = fwd(RegisterB1_IN, OperandB1_IN);
        exp_alu   = ref_alu(int'(ALU_Control1_IN), a, b, int'(ShiftAmount1_IN), Instr1_PC_IN);
        exp_valid = RegWrite1_IN && !MemRead1_IN && WriteRegister1_IN != 0;
        check({tag, "_async"}, ALU_result_async1, exp_alu);
        check({tag, "_async_valid"}, {31'd0, ALU_result_async_valid1}, {31'd0, exp_valid});
        if (FLUSH) begin
            exp_alu = 0; exp_mwd = 0; exp_instr = 0; exp_pc = 0; exp_alt = 0; exp_ctrl = 0;
        end else begin
            exp_mwd   = fwd(RegisterB1_IN, MemWriteData1_IN);
            exp_instr = Instr1_IN;
            exp_pc    = Instr1_PC_IN;
            exp_alt   = Alt_PC;
            exp_ctrl  = {Branch_prediction_IN, Request_Alt_PC, MemWrite1_IN, MemRead1_IN,
                         RegWrite1_IN, ALU_Control1_IN, WriteRegister1_IN};
        end
        @(posedge CLK);
        #1;
        check({tag, "_alu"}, ALU_result1_OUT, exp_alu);
        check({tag, "_mwd"}, MemWriteData1_OUT, exp_mwd);
        check({tag, "_instr"}, Instr1_OUT, exp_instr);
        check({tag, "_pc"}, Instr1_PC_OUT, exp_pc);
        check({tag, "_altpc"}, Alt_PC1, exp_alt);
        check({tag, "_ctrl"}, reg_ctrl(), exp_ctrl);
        @(negedge CLK);
    endtask

    initial begin
        RESET = 0;
        set_random();
        FLUSH = 0;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset_held");
        @(negedge CLK);
        RESET = 1;
        #3;
        check_all_zero("reset_released");
        @(negedge CLK);

        set_quiet(); ALU_Control1_IN = 0; OperandA1_IN = 32'hFFFF_FFFF; OperandB1_IN = 1;
        cycle_and_check("add_wrap");
        check("add_wrap_const", ALU_result1_OUT, 32'h0);

        set_quiet(); ALU_Control1_IN = 6; OperandA1_IN = 32'hFFFF_FFFF; OperandB1_IN = 0;
        cycle_and_check("slt");
        check("slt_const", ALU_result1_OUT, 32'h1);

        set_quiet(); ALU_Control1_IN = 7; OperandA1_IN = 32'hFFFF_FFFF; OperandB1_IN = 0;
        cycle_and_check("sltu");
        check("sltu_const", ALU_result1_OUT, 32'h0);

        set_quiet(); ALU_Control1_IN = 10; OperandB1_IN = 32'h8000_0000; ShiftAmount1_IN = 4;
        cycle_and_check("sra");
        check("sra_const", ALU_result1_OUT, 32'hF800_0000);

        set_quiet(); ALU_Control1_IN = 14; OperandB1_IN = 32'h0000_1234;
        cycle_and_check("lui");
        check("lui_const", ALU_result1_OUT, 32'h1234_0000);

        set_quiet(); ALU_Control1_IN = 16; Instr1_PC_IN = 32'h0040_0010;
        cycle_and_check("link");
        check("link_const", ALU_result1_OUT, 32'h0040_0018);

        set_quiet(); RegisterA1_IN = 5; RegisterB1_IN = 6; OperandA1_IN = 1; OperandB1_IN = 1;
        BypassReg1_MEMEXE = 5; BypassValid1_MEMEXE = 1; BypassData1_MEMEXE = 7;
        cycle_and_check("fwd_a");
        check("fwd_a_const", ALU_result1_OUT, 32'd8);

        set_quiet(); RegisterA1_IN = 5; RegisterB1_IN = 6; OperandA1_IN = 1; OperandB1_IN = 1;
        BypassReg1_MEMEXE = 0; BypassValid1_MEMEXE = 1; BypassData1_MEMEXE = 7;
        cycle_and_check("fwd_none");
        check("fwd_none_const", ALU_result1_OUT, 32'd2);

        set_quiet(); RegisterA1_IN = 0; RegisterB1_IN = 0; OperandA1_IN = 1; OperandB1_IN = 1;
        MemWriteData1_IN = 32'h55; BypassReg1_MEMEXE = 0; BypassValid1_MEMEXE = 1;
        BypassData1_MEMEXE = 7;
        cycle_and_check("fwd_r0");
        check("fwd_r0_const", ALU_result1_OUT, 32'd2);
        check("fwd_r0_mwd_const", MemWriteData1_OUT, 32'h55);

        set_quiet(); RegisterB1_IN = 9; MemWriteData1_IN = 32'h11; MemWrite1_IN = 1;
        RegWrite1_IN = 0; BypassReg1_MEMEXE = 9; BypassValid1_MEMEXE = 1;
        BypassData1_MEMEXE = 32'hCAFE_0000;
        cycle_and_check("fwd_store");
        check("fwd_store_const", MemWriteData1_OUT, 32'hCAFE_0000);

        set_quiet(); RegWrite1_IN = 1; MemRead1_IN = 1; WriteRegister1_IN = 3;
        #1 check("async_valid_load", {31'd0, ALU_result_async_valid1}, 32'd0);
        MemRead1_IN = 0;
        #1 check("async_valid_alu", {31'd0, ALU_result_async_valid1}, 32'd1);
        @(negedge CLK);

        set_quiet(); Request_Alt_PC = 1; Alt_PC = 32'h0040_0100; Branch_prediction_IN = 1;
        cycle_and_check("branch");
        check("branch_req_const", {31'd0, Request_Alt_PC1}, 32'd1);
        check("branch_alt_const", Alt_PC1, 32'h0040_0100);

        FLUSH = 1;
        cycle_and_check("flush");
        check_all_zero("flush_const");

        // Asynchronous reset mid-cycle, with FLUSH also high.
        set_random(); FLUSH = 0;
        @(posedge CLK);
        #2;
        RESET = 0; FLUSH = 1;
        #1;
        check_all_zero("async_reset");
        @(negedge CLK);
        RESET = 1;

        for (int i = 0; i < 400; i++) begin
            set_random();
            cycle_and_check("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
